// File: rtl/multicycle_sequencer_if.sv
// Interface bundling the sequencer's instruction, memory-handshake and
// phase-enable signals. The sequencer uses the slave modport; the
// environment driving run/opcode/func/mem_ready uses the master modport.
interface multicycle_sequencer_if #(
    parameter int INSTRET_WIDTH = 32
);
    logic                     run;
    logic [5:0]               opcode;
    logic [5:0]               func;
    logic                     mem_ready;
    logic [2:0]               state;
    logic                     busy;
    logic                     mem_req;
    logic                     mem_we;
    logic                     iord;
    logic                     ir_write;
    logic                     pc_write;
    logic                     pc_write_cond;
    logic [1:0]               pc_src;
    logic                     reg_write;
    logic [INSTRET_WIDTH-1:0] instret;
    logic                     illegal;

    modport slave (
        input  run, opcode, func, mem_ready,
        output state, busy, mem_req, mem_we, iord, ir_write, pc_write,
               pc_write_cond, pc_src, reg_write, instret, illegal
    );

    modport master (
        output run, opcode, func, mem_ready,
        input  state, busy, mem_req, mem_we, iord, ir_write, pc_write,
               pc_write_cond, pc_src, reg_write, instret, illegal
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS instruction sequencer: FETCH/DECODE/EXEC/MEM/WB phase
// control with a variable-latency memory handshake, retired-instruction
// counter and illegal-opcode detection.
// Optional feature macro: SEQ_TRAP_EN -- when defined, an illegal opcode
// sets a sticky flag and parks the sequencer in HALT until reset; when
// undefined, an illegal opcode retires as a NOP with a one-cycle flag.
module multicycle_sequencer #(
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU     = 3'd0,
        CL_LOAD    = 3'd1,
        CL_STORE   = 3'd2,
        CL_BRANCH  = 3'd3,
        CL_J       = 3'd4,
        CL_JAL     = 3'd5,
        CL_JR      = 3'd6,
        CL_ILLEGAL = 3'd7
    } iclass_t;

    // Map opcode/func to an execution class; jr lives under the R-type opcode.
    function automatic iclass_t decode_class(input logic [5:0] op, input logic [5:0] fn);
        iclass_t cl;
        casez (op)
            6'b000000: cl = (fn == 6'b001000) ? CL_JR : CL_ALU;
            6'b001000, 6'b001001, 6'b001100, 6'b001101,
            6'b001110, 6'b001111, 6'b001010: cl = CL_ALU;
            6'b100011: cl = CL_LOAD;
            6'b101011: cl = CL_STORE;
            6'b0001??, 6'b000001: cl = CL_BRANCH;
            6'b000010: cl = CL_J;
            6'b000011: cl = CL_JAL;
            default:   cl = CL_ILLEGAL;
        endcase
        return cl;
    endfunction

    state_t                   state_q, state_d;
    iclass_t                  class_q, class_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

    logic       end_s;
    logic       illegal_hit_s;
    logic       mem_req_s, mem_we_s, iord_s, ir_write_s, pc_write_s;
    logic       pc_write_cond_s, reg_write_s, busy_s;
    logic [1:0] pc_src_s;

    // Next-state, class latch, retirement count and phase enables.
    always_comb begin
        state_d         = state_q;
        class_d         = class_q;
        instret_d       = instret_q;
        end_s           = 1'b0;
        illegal_hit_s   = 1'b0;
        mem_req_s       = 1'b0;
        mem_we_s        = 1'b0;
        iord_s          = 1'b0;
        ir_write_s      = 1'b0;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        reg_write_s     = 1'b0;
        pc_src_s        = 2'b00;
        busy_s          = (state_q != ST_IDLE) && (state_q != ST_HALT);

        case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_FETCH;
                else         state_d = ST_IDLE;
            end
            ST_FETCH: begin
                mem_req_s = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                class_d = decode_class(bus.opcode, bus.func);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (class_q)
                    CL_ALU:            state_d = ST_WB;
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    CL_BRANCH: begin
                        pc_write_cond_s = 1'b1;
                        pc_src_s        = 2'b01;
                        end_s           = 1'b1;
                    end
                    CL_J: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = 2'b10;
                        end_s      = 1'b1;
                    end
                    CL_JAL: begin
                        pc_write_s  = 1'b1;
                        pc_src_s    = 2'b10;
                        reg_write_s = 1'b1;
                        end_s       = 1'b1;
                    end
                    CL_JR: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = 2'b11;
                        end_s      = 1'b1;
                    end
                    CL_ILLEGAL: begin
                        illegal_hit_s = 1'b1;
`ifdef SEQ_TRAP_EN
                        state_d = ST_HALT;
`else
                        end_s   = 1'b1;
`endif
                    end
                    default: end_s = 1'b1;
                endcase
            end
            ST_MEM: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                mem_we_s  = (class_q == CL_STORE);
                if (bus.mem_ready) begin
                    if (class_q == CL_LOAD) state_d = ST_WB;
                    else                    end_s   = 1'b1;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                reg_write_s = 1'b1;
                end_s       = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        if (end_s) begin
            instret_d = instret_q + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
            state_d   = bus.run ? ST_FETCH : ST_IDLE;
        end else begin
            instret_d = instret_q;
        end
    end

    // Phase state, latched class and retirement counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            class_q   <= CL_ALU;
            instret_q <= {INSTRET_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            instret_q <= instret_d;
        end
    end

`ifdef SEQ_TRAP_EN
    logic illegal_q;

    // Sticky trap flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_q | illegal_hit_s;
    end

    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = illegal_hit_s;
`endif

    assign bus.state         = state_q;
    assign bus.busy          = busy_s;
    assign bus.mem_req       = mem_req_s;
    assign bus.mem_we        = mem_we_s;
    assign bus.iord          = iord_s;
    assign bus.ir_write      = ir_write_s;
    assign bus.pc_write      = pc_write_s;
    assign bus.pc_write_cond = pc_write_cond_s;
    assign bus.pc_src        = pc_src_s;
    assign bus.reg_write     = reg_write_s;
    assign bus.instret       = instret_q;

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle instruction sequencer for the MIPS datapath. It walks each instruction through FETCH, DECODE, EXEC, optional MEM and WB phases, and drives the phase-level enables: PC write, IR write, memory request and register write. It sits beside the combinational instruction decoder, which still supplies ALU/mux controls. It also handshakes with a variable-latency unified memory, retires instructions into a counter and flags illegal opcodes.

## Interface
- `INSTRET_WIDTH`, 32, width of retired-instruction counter
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `run`  in  1  allow new instruction fetch
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `func`  in  6  IR[5:0], valid from DECODE onward
- `mem_ready`  in  1  memory completes current request this cycle
- `state`  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6
- `busy`  out  1  state not IDLE/HALT
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`  out  1  request is a write (store)
- `iord`  out  1  0 = address from PC, 1 = from ALU result
- `ir_write`  out  1  load IR
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if branch condition true (datapath evaluates)
- `pc_src`  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs (jr)
- `reg_write`  out  1  register file write
- `instret`  out  `INSTRET_WIDTH`  retired instruction count
- `illegal`  out  1  sticky illegal-opcode flag

## Operation
- Class latched at end of DECODE from `opcode`/`func`:
  - ALU: opcode 000000 (except func 001000), 001000, 001001, 001100, 001101, 001110, 001111, 001010.
  - LOAD: 100011.
  - STORE: 101011.
  - BRANCH: 0001xx, 000001.
  - JUMP: 000010, 000011 (jal), or 000000 with func 001000 (jr).
  - ILLEGAL: all others.
- IDLE: all outputs 0. Goes to FETCH when `run`=1.
- FETCH: `mem_req`=1, `iord`=0, `mem_we`=0. In the cycle `mem_ready`=1, `ir_write`=1 and `pc_write`=1 with `pc_src`=00, then go to DECODE. Otherwise stay.
- DECODE: single cycle, no enables, then EXEC.
- EXEC by class:
  - ALU goes to WB.
  - LOAD/STORE go to MEM.
  - BRANCH drives `pc_write_cond`=1 with `pc_src`=01, then ends.
  - JUMP drives `pc_write`=1 with `pc_src`=10 (j/jal) or 11 (jr). jal also drives `reg_write`=1. Then ends.
  - ILLEGAL: see Configuration.
- MEM: `mem_req`=1, `iord`=1, `mem_we`=1 for STORE. On `mem_ready`, LOAD goes to WB and STORE ends.
- WB: `reg_write`=1 for one cycle, then ends.
- Instruction end: `instret` increments by 1 (wraps modulo 2^`INSTRET_WIDTH`). Next state is FETCH if `run`=1, else IDLE.
- `run` deasserted mid-instruction: current instruction completes, then IDLE.
- `mem_ready` outside FETCH/MEM is ignored.
- `opcode`/`func` are only sampled in DECODE.

## Timing
- Reset (async, immediate): `state`=IDLE, `instret`=0, `illegal`=0, latched class=ALU. All other outputs are 0 during and after reset until `run`.
- Reset mid-request drops `mem_req` asynchronously, with no completion.
- Outputs are combinational from state and class. `ir_write`, `pc_write` (in FETCH) and the MEM→WB/end transitions additionally depend on `mem_ready` in the same cycle.
- Zero-wait memory (`mem_ready` tied 1), cycles per instruction: ALU 4, LOAD 5, STORE 4, BRANCH/JUMP 3, IDLE→FETCH entry +1.
- Each cycle of `mem_ready`=0 in FETCH/MEM adds one cycle. `mem_req`/`iord`/`mem_we` stay stable throughout the wait.
- `reg_write`, `pc_write`, `pc_write_cond` and `ir_write` are single-cycle pulses per instruction.

## Configuration
- `SEQ_TRAP_EN` defined: ILLEGAL in EXEC sets `illegal`=1 and enters HALT.
  - HALT: all enables 0, `busy`=0, `instret` not incremented. Only reset exits.
- `SEQ_TRAP_EN` undefined: ILLEGAL executes as a NOP. EXEC ends the instruction, `instret` increments and `illegal` pulses 1 for that EXEC cycle only (not sticky). HALT is unreachable.

## Test plan
- Reset, `run`=1, `mem_ready`=1, opcode 001000 (ADDi): states 1,2,3,5,1. `ir_write`/`pc_write` at cycle 1, `reg_write` at cycle 4, `instret`=1.
- LW with `mem_ready` low 3 cycles in MEM: `mem_req`=1 and `iord`=1 held for 4 cycles, then WB `reg_write`=1. Total 8 cycles, `instret` +1.
- SW, then BEQ (000100), then jr (000000/001000) with zero-wait memory: `mem_we`=1 only in SW's MEM cycle; BEQ `pc_write_cond`=1 with `pc_src`=01; jr `pc_write`=1 with `pc_src`=11. `instret`=3 after 11 cycles.
- Opcode 111111:
  - With `SEQ_TRAP_EN`: `state`=6, `illegal`=1 sticky, `instret` unchanged.
  - Without: returns to FETCH, `illegal` pulse, `instret`+1.
- `run` dropped during DECODE: instruction completes, `state`=0, no further `mem_req`. Then `rst_n` low while in FETCH waiting: `mem_req`=0 immediately, `instret`=0.
- `INSTRET_WIDTH`=4: 16 ALU instructions wrap `instret` to 0.
